// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Two-master AHB-Lite data-bus arbiter. M0 (core LSU) has
//               priority; M1 (secondary master, e.g. scrubber) is guaranteed
//               forward progress by a starvation counter. Ownership changes
//               only on a ready cycle, and a master's lock input keeps
//               ownership for atomic read-modify-write sequences.
//               hrdata/hrdcheck do not pass through here.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   s_clk_i, s_reset_i          clock, synchronous active-high reset
//   s_mK_req_i / s_mK_lock_i    master K request / hold ownership
//   s_mK_gnt_o                  master K owns the address phase
//   s_mK_h*_i                   master K address/control/data-phase signals
//   s_mK_hready_o/s_mK_hresp_o  bus ready / error returned to master K
//   s_h*_o                      muxed address phase and data phase to bus
//   s_hready_i, s_hresp_i       bus ready / bus error
// ============================================================================
module dbus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,

    input  logic        s_m0_req_i,
    input  logic        s_m0_lock_i,
    output logic        s_m0_gnt_o,
    input  logic [31:0] s_m0_haddr_i,
    input  logic [1:0]  s_m0_htrans_i,
    input  logic [2:0]  s_m0_hsize_i,
    input  logic        s_m0_hwrite_i,
    input  logic [31:0] s_m0_hwdata_i,
    input  logic [6:0]  s_m0_hwdcheck_i,
    input  logic [5:0]  s_m0_hparity_i,
    output logic        s_m0_hready_o,
    output logic        s_m0_hresp_o,

    input  logic        s_m1_req_i,
    input  logic        s_m1_lock_i,
    output logic        s_m1_gnt_o,
    input  logic [31:0] s_m1_haddr_i,
    input  logic [1:0]  s_m1_htrans_i,
    input  logic [2:0]  s_m1_hsize_i,
    input  logic        s_m1_hwrite_i,
    input  logic [31:0] s_m1_hwdata_i,
    input  logic [6:0]  s_m1_hwdcheck_i,
    input  logic [5:0]  s_m1_hparity_i,
    output logic        s_m1_hready_o,
    output logic        s_m1_hresp_o,

    output logic [31:0] s_haddr_o,
    output logic [2:0]  s_hsize_o,
    output logic        s_hwrite_o,
    output logic [1:0]  s_htrans_o,
    output logic [5:0]  s_hparity_o,
    output logic [31:0] s_hwdata_o,
    output logic [6:0]  s_hwdcheck_o,
    input  logic        s_hready_i,
    input  logic        s_hresp_i
);

    localparam logic [1:0] c_HTRANS_IDLE = 2'b00;
    localparam logic [3:0] c_LIMIT       = 4'(STARVE_LIMIT);

    // Grant state: which master owns the address phase.
    localparam logic [0:0] ST_M0 = 1'b0;
    localparam logic [0:0] ST_M1 = 1'b1;

    logic [0:0] gnt_q, gnt_d;
    logic       dp_active_q, dp_active_d;
    logic       dp_owner_q, dp_owner_d;
    logic       m1_served_q, m1_served_d;
    logic [3:0] cnt_q, cnt_d;

    // Owner's transfer type with a non-requesting owner forced to IDLE.
    // This is the value the bus sees outside reset and drives the
    // data-phase tracking and the served/starvation bookkeeping.
    logic [1:0] w_htrans;
    logic       w_owner_req;
    logic       w_to_m1;
    logic       w_to_m0;

    always_comb begin
        w_owner_req = (gnt_q == ST_M1) ? s_m1_req_i : s_m0_req_i;
        w_htrans    = c_HTRANS_IDLE;
        if (w_owner_req) begin
            w_htrans = (gnt_q == ST_M1) ? s_m1_htrans_i : s_m0_htrans_i;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            gnt_q       <= ST_M0;
            dp_active_q <= 1'b0;
            dp_owner_q  <= 1'b0;
            m1_served_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            gnt_q       <= gnt_d;
            dp_active_q <= dp_active_d;
            dp_owner_q  <= dp_owner_d;
            m1_served_q <= m1_served_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; everything holds while the bus is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d       = gnt_q;
        dp_active_d = dp_active_q;
        dp_owner_d  = dp_owner_q;
        m1_served_d = m1_served_q;
        cnt_d       = cnt_q;
        w_to_m1     = 1'b0;
        w_to_m0     = 1'b0;

        if (s_hready_i) begin
            case (gnt_q)
                ST_M0: begin
                    // Lock beats starvation: a saturated counter just waits.
                    w_to_m1 = s_m1_req_i & ~s_m0_lock_i &
                              (~s_m0_req_i | (cnt_q == c_LIMIT));
                end
                default: begin
                    // M1 yields once it has had one transfer accepted.
                    w_to_m0 = ~s_m1_lock_i &
                              (~s_m1_req_i | (s_m0_req_i & m1_served_q));
                end
            endcase

            if (w_to_m1) begin
                gnt_d = ST_M1;
            end else if (w_to_m0) begin
                gnt_d = ST_M0;
            end

            // The phase on the bus now becomes next cycle's data phase.
            dp_active_d = w_htrans[1];
            dp_owner_d  = gnt_q;

            if (w_to_m0) begin
                m1_served_d = 1'b0;
            end else if ((gnt_q == ST_M1) && w_htrans[1]) begin
                m1_served_d = 1'b1;
            end

            if (!s_m1_req_i || w_to_m1) begin
                cnt_d = 4'd0;
            end else if ((gnt_q == ST_M0) && w_htrans[1] && (cnt_q != c_LIMIT)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_m0_gnt_o    = ~s_reset_i & (gnt_q == ST_M0);
        s_m1_gnt_o    = ~s_reset_i & (gnt_q == ST_M1);

        s_htrans_o    = s_reset_i ? c_HTRANS_IDLE : w_htrans;
        s_haddr_o     = (gnt_q == ST_M1) ? s_m1_haddr_i   : s_m0_haddr_i;
        s_hsize_o     = (gnt_q == ST_M1) ? s_m1_hsize_i   : s_m0_hsize_i;
        s_hwrite_o    = (gnt_q == ST_M1) ? s_m1_hwrite_i  : s_m0_hwrite_i;
        s_hparity_o   = (gnt_q == ST_M1) ? s_m1_hparity_i : s_m0_hparity_i;

        s_hwdata_o    = dp_owner_q ? s_m1_hwdata_i   : s_m0_hwdata_i;
        s_hwdcheck_o  = dp_owner_q ? s_m1_hwdcheck_i : s_m0_hwdcheck_i;

        s_m0_hready_o = s_hready_i;
        s_m1_hready_o = s_hready_i;

        // Errors go only to the master whose data phase is in flight.
        s_m0_hresp_o  = ~s_reset_i & s_hresp_i & dp_active_q & ~dp_owner_q;
        s_m1_hresp_o  = ~s_reset_i & s_hresp_i & dp_active_q &  dp_owner_q;
    end

endmodule
`default_nettype wire
